// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: EX->MEM and MEM->WB register banks, dcache handshake, halt FSM.
// Optional stall-cycle performance counter is built only when MEM_STAGE_PERF_EN is defined.
module mem_stage_pipe #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic              ex_RegWr,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_halt,
    input  logic [REG_AW-1:0] ex_wsel,
    input  logic [WORD_W-1:0] ex_alu_out,
    input  logic [WORD_W-1:0] ex_store_data,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              RegWr_MEM,
    output logic              load_MEM,
    output logic [REG_AW-1:0] wsel_MEM,
    output logic [WORD_W-1:0] fwd_data_MEM,
    output logic              RegWr_WB,
    output logic [REG_AW-1:0] wsel_WB,
    output logic [WORD_W-1:0] wdat_WB,
    output logic              halt,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              mem_valid_q, mem_valid_d;
    logic              mem_regwr_q, mem_regwr_d;
    logic              mem_dren_q,  mem_dren_d;
    logic              mem_dwen_q,  mem_dwen_d;
    logic              mem_halt_q,  mem_halt_d;
    logic [REG_AW-1:0] mem_wsel_q,  mem_wsel_d;
    logic [WORD_W-1:0] mem_alu_q,   mem_alu_d;
    logic [WORD_W-1:0] mem_store_q, mem_store_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_regwr_q, wb_regwr_d;
    logic [REG_AW-1:0] wb_wsel_q,  wb_wsel_d;
    logic [WORD_W-1:0] wb_wdat_q,  wb_wdat_d;

    logic halt_capture;

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A valid halt leaving MEM this cycle lands in WB at the next edge
    assign halt_capture = mem_valid_q & mem_halt_q & ~mem_stall;

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mem_stall) state_d = S_ACCESS;
            S_ACCESS: if (dhit)      state_d = S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        if (state_q != S_HALTED && halt_capture) begin
            state_d = S_HALTED;
        end
    end

    // FSM outputs: dcache requests are combinational from the MEM bank, muted once halted
    always_comb begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        case (state_q)
            S_IDLE, S_ACCESS: begin
                dmemREN = mem_valid_q & mem_dren_q;
                dmemWEN = mem_valid_q & mem_dwen_q;
            end
            default: begin
                dmemREN = 1'b0;
                dmemWEN = 1'b0;
            end
        endcase
        mem_stall = (dmemREN | dmemWEN) & ~dhit;
    end

    // EX->MEM bank: load when not stalled, otherwise hold (flush ignored)
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_regwr_d = mem_regwr_q;
        mem_dren_d  = mem_dren_q;
        mem_dwen_d  = mem_dwen_q;
        mem_halt_d  = mem_halt_q;
        mem_wsel_d  = mem_wsel_q;
        mem_alu_d   = mem_alu_q;
        mem_store_d = mem_store_q;
        if (!mem_stall) begin
            mem_valid_d = ex_valid & ~flush;
            mem_regwr_d = ex_RegWr;
            mem_dren_d  = ex_dREN;
            mem_dwen_d  = ex_dWEN;
            mem_halt_d  = ex_halt;
            mem_wsel_d  = ex_wsel;
            mem_alu_d   = ex_alu_out;
            mem_store_d = ex_store_data;
        end
    end

    // MEM->WB bank: bubble while stalled
    always_comb begin
        wb_valid_d = 1'b0;
        wb_regwr_d = wb_regwr_q;
        wb_wsel_d  = wb_wsel_q;
        wb_wdat_d  = wb_wdat_q;
        if (!mem_stall) begin
            wb_valid_d = mem_valid_q;
            wb_regwr_d = mem_regwr_q;
            wb_wsel_d  = mem_wsel_q;
            wb_wdat_d  = mem_dren_q ? dmemload : mem_alu_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_valid_q <= 1'b0;
            mem_regwr_q <= 1'b0;
            mem_dren_q  <= 1'b0;
            mem_dwen_q  <= 1'b0;
            mem_halt_q  <= 1'b0;
            mem_wsel_q  <= '0;
            mem_alu_q   <= '0;
            mem_store_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_regwr_q  <= 1'b0;
            wb_wsel_q   <= '0;
            wb_wdat_q   <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_regwr_q <= mem_regwr_d;
            mem_dren_q  <= mem_dren_d;
            mem_dwen_q  <= mem_dwen_d;
            mem_halt_q  <= mem_halt_d;
            mem_wsel_q  <= mem_wsel_d;
            mem_alu_q   <= mem_alu_d;
            mem_store_q <= mem_store_d;
            wb_valid_q  <= wb_valid_d;
            wb_regwr_q  <= wb_regwr_d;
            wb_wsel_q   <= wb_wsel_d;
            wb_wdat_q   <= wb_wdat_d;
        end
    end

    assign halt         = (state_q == S_HALTED);
    assign dmemaddr     = mem_alu_q;
    assign dmemstore    = mem_store_q;
    assign RegWr_MEM    = mem_valid_q & mem_regwr_q;
    assign load_MEM     = mem_valid_q & mem_dren_q;
    assign wsel_MEM     = mem_wsel_q;
    assign fwd_data_MEM = mem_alu_q;
    // Halted suppresses the halt's own writeback and everything after it
    assign RegWr_WB     = wb_valid_q & wb_regwr_q & ~halt;
    assign wsel_WB      = wb_wsel_q;
    assign wdat_WB      = wb_wdat_q;

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Randomized and directed bench for mem_stage_pipe against a slot-level pipeline model.
module tb_mem_stage_pipe;

    logic        CLK;
    logic        RST;
    logic        ex_valid, ex_RegWr, ex_dREN, ex_dWEN, ex_halt;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_alu_out, ex_store_data;
    logic        flush, dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        mem_stall, RegWr_MEM, load_MEM;
    logic [4:0]  wsel_MEM;
    logic [31:0] fwd_data_MEM;
    logic        RegWr_WB;
    logic [4:0]  wsel_WB;
    logic [31:0] wdat_WB;
    logic        halt;
    logic [31:0] stall_cycles;

    mem_stage_pipe #(.WORD_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_RegWr(ex_RegWr), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
        .ex_halt(ex_halt), .ex_wsel(ex_wsel), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .RegWr_MEM(RegWr_MEM), .load_MEM(load_MEM),
        .wsel_MEM(wsel_MEM), .fwd_data_MEM(fwd_data_MEM), .RegWr_WB(RegWr_WB),
        .wsel_WB(wsel_WB), .wdat_WB(wdat_WB), .halt(halt), .stall_cycles(stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Instruction occupying a pipeline slot
    typedef struct {
        logic        v;
        logic        regwr;
        logic        dren;
        logic        dwen;
        logic        hlt;
        logic [4:0]  wsel;
        logic [31:0] alu;
        logic [31:0] st;
    } slot_t;

    slot_t           m_mem;
    logic            m_wb_v, m_wb_regwr;
    logic [4:0]      m_wb_wsel;
    logic [31:0]     m_wb_wdat;
    bit              m_halted;
    longint unsigned m_stalls;

    function automatic void model_reset();
        m_mem      = '{v: 1'b0, regwr: 1'b0, dren: 1'b0, dwen: 1'b0, hlt: 1'b0,
                       wsel: 5'd0, alu: 32'd0, st: 32'd0};
        m_wb_v     = 1'b0;
        m_wb_regwr = 1'b0;
        m_wb_wsel  = 5'd0;
        m_wb_wdat  = 32'd0;
        m_halted   = 1'b0;
        m_stalls   = 0;
    endfunction

    function automatic logic m_rd();
        return !m_halted && m_mem.v && m_mem.dren;
    endfunction

    function automatic logic m_wr();
        return !m_halted && m_mem.v && m_mem.dwen;
    endfunction

    function automatic logic m_stall();
        return (m_rd() || m_wr()) && !dhit;
    endfunction

    function automatic logic [31:0] m_stall_cnt();
`ifdef MEM_STAGE_PERF_EN
        return (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
`else
        return 32'd0;
`endif
    endfunction

    // Advance the model across one rising edge using the inputs currently driven
    function automatic void model_update();
        if (m_stall()) begin
            m_wb_v = 1'b0;
            m_stalls++;
        end else begin
            m_wb_v     = m_mem.v;
            m_wb_regwr = m_mem.regwr;
            m_wb_wsel  = m_mem.wsel;
            m_wb_wdat  = m_mem.dren ? dmemload : m_mem.alu;
            if (m_mem.v && m_mem.hlt) m_halted = 1'b1;
            m_mem = '{v: ex_valid & ~flush, regwr: ex_RegWr, dren: ex_dREN, dwen: ex_dWEN,
                      hlt: ex_halt, wsel: ex_wsel, alu: ex_alu_out, st: ex_store_data};
        end
    endfunction

    task automatic check_outputs();
        logic wb_wr;
        wb_wr = m_wb_v && m_wb_regwr && !m_halted;
        check("dmemREN", 32'(dmemREN), 32'(m_rd()));
        check("dmemWEN", 32'(dmemWEN), 32'(m_wr()));
        if (m_rd() || m_wr()) begin
            check("dmemaddr", dmemaddr, m_mem.alu);
            check("dmemstore", dmemstore, m_mem.st);
        end
        check("mem_stall", 32'(mem_stall), 32'(m_stall()));
        check("RegWr_MEM", 32'(RegWr_MEM), 32'(m_mem.v && m_mem.regwr));
        check("load_MEM", 32'(load_MEM), 32'(m_mem.v && m_mem.dren));
        check("wsel_MEM", 32'(wsel_MEM), 32'(m_mem.wsel));
        check("fwd_data_MEM", fwd_data_MEM, m_mem.alu);
        check("RegWr_WB", 32'(RegWr_WB), 32'(wb_wr));
        if (wb_wr) begin
            check("wsel_WB", 32'(wsel_WB), 32'(m_wb_wsel));
            check("wdat_WB", wdat_WB, m_wb_wdat);
        end
        check("halt", 32'(halt), 32'(m_halted));
        check("stall_cycles", stall_cycles, m_stall_cnt());
    endtask

    task automatic drive(input logic v, input logic rw, input logic rd, input logic wr,
                         input logic h, input logic [4:0] ws, input logic [31:0] alu,
                         input logic [31:0] st, input logic fl, input logic dh,
                         input logic [31:0] ld);
        ex_valid = v; ex_RegWr = rw; ex_dREN = rd; ex_dWEN = wr; ex_halt = h;
        ex_wsel = ws; ex_alu_out = alu; ex_store_data = st;
        flush = fl; dhit = dh; dmemload = ld;
    endtask

    task automatic idle(input logic fl, input logic dh, input logic [31:0] ld);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, fl, dh, ld);
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    // Reset asserted half a cycle in, checked before any clock edge
    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_dmemREN", 32'(dmemREN), 32'd0);
        check("rst_dmemWEN", 32'(dmemWEN), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_RegWr_MEM", 32'(RegWr_MEM), 32'd0);
        check("rst_RegWr_WB", 32'(RegWr_WB), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int stall_seen;
        RST = 1'b1;
        idle(1'b0, 1'b0, 32'd0);
        model_reset();
        @(negedge CLK);
        do_reset();
        settle();

        // ALU op flows MEM then WB with no stall
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0);
        settle(); advance();
        idle(1'b0, 1'b0, 32'd0);
        settle();
        check("alu_c1_RegWr_MEM", 32'(RegWr_MEM), 32'd1);
        check("alu_c1_wsel_MEM", 32'(wsel_MEM), 32'd5);
        advance();
        settle();
        check("alu_c2_RegWr_WB", 32'(RegWr_WB), 32'd1);
        check("alu_c2_wdat_WB", wdat_WB, 32'h10);
        advance();

        // Load with dhit three cycles late
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0);
        settle(); advance();
        stall_seen = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0, 32'h1234_5678);
            settle();
            check("ld_addr", dmemaddr, 32'h40);
            if (mem_stall) stall_seen++;
            advance();
        end
        idle(1'b0, 1'b1, 32'hDEAD_BEEF);
        settle();
        check("ld_hit_stall", 32'(mem_stall), 32'd0);
        advance();
        idle(1'b0, 1'b0, 32'd0);
        settle();
        check("ld_stall_seen", 32'(stall_seen), 32'd3);
        check("ld_RegWr_WB", 32'(RegWr_WB), 32'd1);
        check("ld_wdat_WB", wdat_WB, 32'hDEAD_BEEF);
`ifdef MEM_STAGE_PERF_EN
        check("ld_stall_cycles", stall_cycles, 32'd3);
`else
        check("ld_stall_cycles", stall_cycles, 32'd0);
`endif
        advance();

        // Store completing in the same cycle
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h88, 32'hCAFE, 1'b0, 1'b0, 32'd0);
        settle(); advance();
        idle(1'b0, 1'b1, 32'd0);
        settle();
        check("st_dmemWEN", 32'(dmemWEN), 32'd1);
        check("st_stall", 32'(mem_stall), 32'd0);
        advance();
        idle(1'b0, 1'b0, 32'd0);
        settle();
        check("st_dmemWEN_off", 32'(dmemWEN), 32'd0);
        check("st_RegWr_WB", 32'(RegWr_WB), 32'd0);
        advance();

        // Flush during a stall is ignored; flush with dhit bubbles the next MEM slot
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h50, 32'd0, 1'b0, 1'b0, 32'd0);
        settle(); advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h77, 32'd0, 1'b1, 1'b0, 32'd0);
            settle();
            check("fl_load_held", 32'(load_MEM), 32'd1);
            advance();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h77, 32'd0, 1'b1, 1'b1, 32'hABCD);
        settle(); advance();
        idle(1'b0, 1'b0, 32'd0);
        settle();
        check("fl_bubble_RegWr_MEM", 32'(RegWr_MEM), 32'd0);
        check("fl_wdat_WB", wdat_WB, 32'hABCD);
        advance();

        // Halt followed by a store
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h99, 32'd0, 1'b0, 1'b0, 32'd0);
        settle(); advance();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h80, 32'h55, 1'b0, 1'b0, 32'd0);
        settle(); advance();
        idle(1'b0, 1'b0, 32'd0);
        settle();
        check("hlt_halt", 32'(halt), 32'd1);
        check("hlt_no_store", 32'(dmemWEN), 32'd0);
        check("hlt_own_wb", 32'(RegWr_WB), 32'd0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 32'h60, 32'h1, 1'b0, 1'b0, 32'd0);
            settle();
            check("hlt_post_wb", 32'(RegWr_WB), 32'd0);
            check("hlt_post_req", 32'(dmemWEN), 32'd0);
            advance();
        end

        // Reset in the middle of an outstanding load
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h44, 32'd0, 1'b0, 1'b0, 32'd0);
        settle(); advance();
        idle(1'b0, 1'b0, 32'd0);
        settle(); advance();
        settle();
        check("acc_dmemREN_before", 32'(dmemREN), 32'd1);
        do_reset();
        settle();
        check("acc_after_load_MEM", 32'(load_MEM), 32'd0);
        advance();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int unsigned kind;
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end
            kind = $urandom_range(0, 3);
            drive($urandom_range(0, 3) != 0, 1'($urandom), kind == 0, kind == 1,
                  $urandom_range(0, 299) == 0, 5'($urandom), $urandom, $urandom,
                  $urandom_range(0, 7) == 0, 1'($urandom), $urandom);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
